// File: rtl/sensor_poll_scheduler.sv
// Sensor poll scheduler: collects light/MPU/RH-temp events and a periodic
// forced-poll tick into pending flags and feeds one shared I2C engine.
// Ports:
//   clk_clk, reset_reset    clock, synchronous active-high reset
//   enable                  allow new grants (pending still accumulates)
//   src_event[2:0]          raw events: light_int, mpu_int, rh_temp_drdy_n
//   cmd_valid/cmd_src       command request and source id to the engine
//   cmd_ready               engine accepts the command
//   done_valid/done_err     completion pulse and its error qualifier
//   abort                   one-cycle pulse dropping a timed-out transfer
//   pending, err_flag       pending flags and sticky per-source errors
//   err_clr                 clears err_flag
//   busy                    high whenever a transaction is in progress
// Optional: define SENSOR_SCHED_MPU_PRIORITY_EN to always grant the MPU
// first, with light and RH/temp rotating round-robin between themselves.
module sensor_poll_scheduler #(
  parameter int unsigned POLL_PERIOD    = 500000,
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter logic [2:0]  INT_POL        = 3'b100
) (
  input  logic       clk_clk,
  input  logic       reset_reset,
  input  logic       enable,
  input  logic [2:0] src_event,
  output logic       cmd_valid,
  output logic [1:0] cmd_src,
  input  logic       cmd_ready,
  input  logic       done_valid,
  input  logic       done_err,
  output logic       abort,
  output logic [2:0] pending,
  output logic [2:0] err_flag,
  input  logic       err_clr,
  output logic       busy
);

  localparam int PW =
    (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
  localparam int TW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [PW-1:0] POLL_LAST =
    PW'((POLL_PERIOD == 0) ? 0 : POLL_PERIOD - 1);
  localparam logic [TW-1:0] TMO_LAST =
    TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RECOVER
  } state_t;

  state_t state_q, state_d;

  logic [2:0]    sync1, sync2, level_q;
  logic [2:0]    level, rise;
  logic [PW-1:0] poll_cnt;
  logic          poll_wrap;
  logic [TW-1:0] tmo_cnt, tmo_d;
  logic [1:0]    last_grant, last_d, last_upd;
  logic [1:0]    src_d;
  logic [2:0]    clr_mask, err_set;

  // Sync registers reset to the idle level so no edge fires out of reset.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      sync1   <= INT_POL;
      sync2   <= INT_POL;
      level_q <= '0;
    end else begin
      sync1   <= src_event;
      sync2   <= sync1;
      level_q <= level;
    end
  end

  assign level = sync2 ^ INT_POL;
  assign rise  = level & ~level_q;

  assign poll_wrap =
    (POLL_PERIOD != 0) && (poll_cnt == POLL_LAST);

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      poll_cnt <= '0;
    end else if (poll_wrap || POLL_PERIOD == 0) begin
      poll_cnt <= '0;
    end else begin
      poll_cnt <= poll_cnt + 1'b1;
    end
  end

  function automatic logic [1:0] pick(
    input logic [2:0] req,
    input logic [1:0] last
  );
    logic [1:0] a, b, c;
`ifdef SENSOR_SCHED_MPU_PRIORITY_EN
    a = 2'd1;
    if (last == 2'd0) begin
      b = 2'd2;
      c = 2'd0;
    end else begin
      b = 2'd0;
      c = 2'd2;
    end
`else
    unique case (last)
      2'd0: begin
        a = 2'd1; b = 2'd2; c = 2'd0;
      end
      2'd1: begin
        a = 2'd2; b = 2'd0; c = 2'd1;
      end
      default: begin
        a = 2'd0; b = 2'd1; c = 2'd2;
      end
    endcase
`endif
    if (req[a]) begin
      pick = a;
    end else if (req[b]) begin
      pick = b;
    end else begin
      pick = c;
    end
  endfunction

`ifdef SENSOR_SCHED_MPU_PRIORITY_EN
  // The MPU is outside the rotation, so it never moves the pointer.
  assign last_upd =
    (cmd_src == 2'd1) ? last_grant : cmd_src;
`else
  assign last_upd = cmd_src;
`endif

  always_comb begin
    state_d  = state_q;
    src_d    = cmd_src;
    last_d   = last_grant;
    tmo_d    = tmo_cnt;
    clr_mask = '0;
    err_set  = '0;
    unique case (state_q)
      IDLE: begin
        if (enable && (|pending)) begin
          src_d           = pick(pending, last_grant);
          clr_mask[src_d] = 1'b1;
          state_d         = ISSUE;
        end
      end
      ISSUE: begin
        if (cmd_ready) begin
          tmo_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // Completion beats an expiring timeout in the same cycle.
        if (done_valid) begin
          last_d  = last_upd;
          state_d = IDLE;
          if (done_err) begin
            err_set[cmd_src] = 1'b1;
          end
        end else if (tmo_cnt == TMO_LAST) begin
          err_set[cmd_src] = 1'b1;
          state_d          = RECOVER;
        end else begin
          tmo_d = tmo_cnt + 1'b1;
        end
      end
      RECOVER: begin
        last_d  = last_upd;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Sets are ORed in after clears so a same-cycle set always wins.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      cmd_src    <= 2'd0;
      last_grant <= 2'd2;
      tmo_cnt    <= '0;
      pending    <= '0;
      err_flag   <= '0;
    end else begin
      cmd_src    <= src_d;
      last_grant <= last_d;
      tmo_cnt    <= tmo_d;
      pending    <= (pending & ~clr_mask) | rise
                  | {3{poll_wrap}};
      err_flag   <= (err_clr ? 3'b000 : err_flag)
                  | err_set;
    end
  end

  assign cmd_valid = (state_q == ISSUE);
  assign abort     = (state_q == RECOVER);
  assign busy      = (state_q != IDLE);

endmodule

// File: doc/sensor_poll_scheduler.md
Name: sensor_poll_scheduler

Overview:
- Sequences read transactions for the three board sensors (light, MPU, RH/temp) onto one shared I2C transaction engine.
- Collects data-ready/interrupt events and a periodic forced-poll tick into per-source pending flags, then arbitrates them round-robin.
- Issues one command at a time over a valid/ready handshake, waits for completion, and enforces a timeout.
- Sits between the sensor interrupt pins and the I2C engine inside nios_qsys.

Parameters:
- POLL_PERIOD, 500000: clock cycles between forced polls of all sources; 0 disables the poll timer.
- TIMEOUT_CYCLES, 50000: maximum WAIT-state cycles before a transaction is aborted; must be at least 2.
- INT_POL, 3'b100: per-source polarity; bit=1 means active-low (bit2 = rh_temp drdy_n).

Ports:
- clk_clk  in  1  system clock.
- reset_reset  in  1  synchronous, active-high reset.
- enable  in  1  grant enable; pending flags still accumulate while low.
- src_event  in  3  raw asynchronous events: bit0 light_int, bit1 mpu_int, bit2 rh_temp_drdy_n.
- cmd_valid  out  1  command request to the I2C engine.
- cmd_src  out  2  source ID for the command: 0 light, 1 mpu, 2 rh_temp.
- cmd_ready  in  1  engine accepts the command.
- done_valid  in  1  one-cycle completion pulse from the engine.
- done_err  in  1  NACK/bus error, qualified by done_valid.
- abort  out  1  one-cycle pulse telling the engine to drop the current transaction.
- pending  out  3  current pending flags.
- err_flag  out  3  sticky per-source error (done_err or timeout).
- err_clr  in  1  clears err_flag.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values:
  - cmd_valid, abort, busy, pending, err_flag = 0; cmd_src = 0.
  - State = IDLE; poll counter = 0; timeout counter = 0.
  - last_grant = 2, so the first grant goes to source 0.
- Input path, per bit:
  - 2-FF synchroniser, then XOR with INT_POL.
  - Rising-edge detect on the normalised signal sets pending[i].
  - Latency: a raw edge sets pending 3 cycles later.
- Poll timer:
  - Counts 0..POLL_PERIOD-1, then wraps.
  - On wrap, sets pending[2:0] = 3'b111.
  - Runs regardless of enable.
- Pending priority:
  - A set and a clear of the same bit in the same cycle: the set wins.
  - Repeated events for a bit that is already pending coalesce.
- FSM states: IDLE, ISSUE, WAIT, RECOVER.
  - IDLE:
    - If enable && |pending: select the first pending source scanning last_grant+1, +2, +3 (mod 3).
    - Latch the selection into cmd_src, clear its pending bit, go to ISSUE.
    - cmd_valid rises on the following cycle.
  - ISSUE:
    - cmd_valid = 1; cmd_src is held stable.
    - On cmd_valid && cmd_ready: cmd_valid drops next cycle, timeout counter is cleared, go to WAIT.
  - WAIT:
    - On done_valid: last_grant <= cmd_src; if done_err, set err_flag[cmd_src]; go to IDLE.
    - Else if timeout counter == TIMEOUT_CYCLES-1: set err_flag[cmd_src], go to RECOVER.
    - Else increment the timeout counter.
  - RECOVER:
    - abort = 1 for exactly one cycle; last_grant <= cmd_src; go to IDLE.
- done_valid outside WAIT is ignored.
- A done_valid in the same cycle the timeout expires counts as completion (no abort).
- enable low does not stop an in-flight transaction; it only blocks new grants in IDLE.
- err_clr clears all err_flag bits; a set in the same cycle wins for that bit.
- Reset asserted mid-transaction returns to IDLE immediately with no abort pulse; the engine is reset by the same signal.
- Minimum back-to-back spacing: done_valid to next cmd_valid is 2 cycles (IDLE, then ISSUE).

Optional Feature:
- Macro: SENSOR_SCHED_MPU_PRIORITY_EN.
- When defined: in IDLE, if pending[1] is set it is always granted first. Sources 0 and 2 rotate round-robin among themselves; last_grant updates only when the grant is to source 0 or 2.
- When undefined: pure 3-way round-robin as described under Behaviour.

Test Plan:
- Reset, then pulse src_event=3'b001 with POLL_PERIOD=0 -> pending=001 after 3 cycles; cmd_valid with cmd_src=0 one cycle after IDLE grants; with cmd_ready=1, WAIT; done_valid -> IDLE, err_flag=000.
- All three sources pending simultaneously, engine completes each in 10 cycles -> grants in order 0, 1, 2; then a new event on 0 -> granted 0.
- rh_temp_drdy_n driven high-to-low (active-low, INT_POL bit2=1) -> pending[2] set; low-to-high -> no pending.
- TIMEOUT_CYCLES=20, no done_valid -> abort pulses once 21 cycles after the handshake; err_flag[cmd_src]=1; err_clr -> 000.
- cmd_ready held low for 50 cycles -> cmd_valid and cmd_src stay stable and no timeout fires; then ready -> normal completion.
- With SENSOR_SCHED_MPU_PRIORITY_EN, sources 0 and 1 pending and last_grant=0 -> source 1 is granted first, then source 0.
